// File: rtl/pwm_timer_pkg.sv
// ============================================================================
// pwm_timer_pkg : shared width default and mode encodings for the PWM/timer
// Revision: 1.0
// ============================================================================
`default_nettype none

package pwm_timer_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // mode input encoding
    localparam logic MODE_TIMER  = 1'b0;
    localparam logic MODE_PWM    = 1'b1;

    // timer_mode input encoding (only meaningful in timer mode)
    localparam logic TMR_ONESHOT = 1'b0;
    localparam logic TMR_CONT    = 1'b1;

endpackage : pwm_timer_pkg

`default_nettype wire

// File: rtl/pwm_timer_counter.sv
// ============================================================================
// pwm_timer_counter : tick-enabled main counter with wrap / one-shot hold and
// the timer_done event flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_timer_counter
    import pwm_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             chosen_clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             sw_rst,
    input  logic             counter_en,
    input  logic             mode,
    input  logic             timer_mode,
    input  logic [WIDTH-1:0] period_reg,
    output logic [WIDTH-1:0] counter,
    output logic             timer_done
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_counter;
    logic             r_timer_done;

    logic             w_adv;
    logic             w_period_zero;
    logic [WIDTH-1:0] w_period_m1;
    logic             w_at_end;
    logic             w_oneshot;
    logic [WIDTH-1:0] w_count_inc;

    assign w_adv         = counter_en & tick;
    assign w_period_zero = (period_reg == c_zero);
    assign w_period_m1   = period_reg - c_one;
    // ">=" rather than "==" so a period lowered below the current count wraps at once
    assign w_at_end      = !w_period_zero && (r_counter >= w_period_m1);
    assign w_oneshot     = (mode == MODE_TIMER) && (timer_mode == TMR_ONESHOT);
    assign w_count_inc   = w_period_zero ? c_zero : (r_counter + c_one);

    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst) begin
            r_counter    <= c_zero;
            r_timer_done <= 1'b0;
        end else if (sw_rst) begin
            r_counter    <= c_zero;
            r_timer_done <= 1'b0;
        end else if (w_adv) begin
            if (w_oneshot) begin
                // one-shot: park at period-1 and latch a sticky done
                if (w_at_end) begin
                    r_timer_done <= 1'b1;
                end else begin
                    r_counter <= w_count_inc;
                end
            end else begin
                r_counter    <= w_at_end ? c_zero : w_count_inc;
                r_timer_done <= (mode == MODE_TIMER) && (timer_mode == TMR_CONT) && w_at_end;
            end
        end else if (!w_oneshot) begin
            r_timer_done <= 1'b0;
        end
    end

    assign counter    = r_counter;
    assign timer_done = r_timer_done;

endmodule : pwm_timer_counter

`default_nettype wire

// File: rtl/pwm_timer_core.sv
// ============================================================================
// pwm_timer_core : counter plus duty-cycle select and PWM comparator; an
// out-of-range duty cycle passes the clock through as an error indication.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_timer_core
    import pwm_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             chosen_clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             sw_rst,
    input  logic             counter_en,
    input  logic             mode,
    input  logic             timer_mode,
    input  logic             pwm_en,
    input  logic             DC_sel,
    input  logic [WIDTH-1:0] i_DC,
    input  logic [WIDTH-1:0] period_reg,
    input  logic [WIDTH-1:0] DC_reg,
    output logic [WIDTH-1:0] counter,
    output logic             pwm,
    output logic             timer_done
);

    logic [WIDTH-1:0] w_counter;
    logic [WIDTH-1:0] w_dc;
    logic             w_dc_invalid;
    logic             w_pwm_active;

    pwm_timer_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .chosen_clk (chosen_clk),
        .rst        (rst),
        .tick       (tick),
        .sw_rst     (sw_rst),
        .counter_en (counter_en),
        .mode       (mode),
        .timer_mode (timer_mode),
        .period_reg (period_reg),
        .counter    (w_counter),
        .timer_done (timer_done)
    );

    assign w_dc         = DC_sel ? i_DC : DC_reg;
    assign w_dc_invalid = (w_dc > period_reg);
    assign w_pwm_active = !rst && pwm_en && (mode == MODE_PWM);

    // zero-latency output: compares the registered count against live inputs
    always_comb begin
        pwm = 1'b0;
        if (w_pwm_active) begin
            pwm = w_dc_invalid ? chosen_clk : (w_counter < w_dc);
        end
    end

    assign counter = w_counter;

endmodule : pwm_timer_core

`default_nettype wire

// File: tb/tb_pwm_timer_core.sv
// ============================================================================
// tb_pwm_timer_core : vector table, directed corner sequences and a random run
// against an arithmetic reference model of the PWM/timer core.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pwm_timer_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic         sw_rst;
    logic         counter_en;
    logic         mode;
    logic         timer_mode;
    logic         pwm_en;
    logic         DC_sel;
    logic [W-1:0] i_DC;
    logic [W-1:0] period_reg;
    logic [W-1:0] DC_reg;
    logic [W-1:0] counter;
    logic         pwm;
    logic         timer_done;

    int total = 0;
    int bad   = 0;

    int m_cnt  = 0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    pwm_timer_core #(.WIDTH(W)) dut (
        .chosen_clk (clk),
        .rst        (rst),
        .tick       (tick),
        .sw_rst     (sw_rst),
        .counter_en (counter_en),
        .mode       (mode),
        .timer_mode (timer_mode),
        .pwm_en     (pwm_en),
        .DC_sel     (DC_sel),
        .i_DC       (i_DC),
        .period_reg (period_reg),
        .DC_reg     (DC_reg),
        .counter    (counter),
        .pwm        (pwm),
        .timer_done (timer_done)
    );

    typedef struct {
        string      name;
        int         period;
        int         dc_reg;
        int         i_dc;
        bit         dc_sel;
        bit         invalid;
        logic [7:0] mask;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: count modulo period, one-shot parks at period-1.
    task automatic model_step();
        int p;
        bit oneshot;
        p = int'(period_reg);
        oneshot = (mode == 1'b0) && (timer_mode == 1'b0);
        if (sw_rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (counter_en && tick) begin
            if (p == 0) begin
                m_cnt = 0;
                if (!oneshot) m_done = 1'b0;
            end else if (m_cnt + 1 >= p) begin
                if (oneshot) begin
                    m_done = 1'b1;
                end else begin
                    m_cnt  = 0;
                    m_done = (mode == 1'b0);
                end
            end else begin
                m_cnt = m_cnt + 1;
                if (!oneshot) m_done = 1'b0;
            end
        end else if (!oneshot) begin
            m_done = 1'b0;
        end
    endtask

    function automatic logic exp_pwm();
        int dc;
        if (rst || !pwm_en || !mode) return 1'b0;
        dc = DC_sel ? int'(i_DC) : int'(DC_reg);
        if (dc > int'(period_reg)) return clk;
        return (m_cnt < dc);
    endfunction

    task automatic edge_step();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic soft_clear();
        sw_rst = 1'b1;
        edge_step();
        sw_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"duty50_reg",   6, 3, 0, 1'b0, 1'b0, 8'b0000_0111};
        vecs[1] = '{"duty25_reg",   4, 1, 0, 1'b0, 1'b0, 8'b0000_0001};
        vecs[2] = '{"duty75_ext",   4, 0, 3, 1'b1, 1'b0, 8'b0000_0111};
        vecs[3] = '{"dc_zero",      5, 0, 0, 1'b0, 1'b0, 8'b0000_0000};
        vecs[4] = '{"dc_eq_period", 5, 5, 0, 1'b0, 1'b0, 8'b0001_1111};
        vecs[5] = '{"inval_reg",    3, 4, 0, 1'b0, 1'b1, 8'b0000_0000};
        vecs[6] = '{"inval_ext",    2, 0, 3, 1'b1, 1'b1, 8'b0000_0000};

        rst = 1'b1; tick = 1'b1; sw_rst = 1'b0; counter_en = 1'b1;
        mode = 1'b1; timer_mode = 1'b0; pwm_en = 1'b1; DC_sel = 1'b0;
        i_DC = '0; period_reg = 16'd6; DC_reg = 16'd3;
        #1;
        check("reset_counter", counter, 0);
        check("reset_pwm", pwm, 0);
        check("reset_done", timer_done, 0);
        @(negedge clk);
        rst = 1'b0;

        // table-driven PWM waveforms over two periods
        foreach (vecs[i]) begin
            mode = 1'b1; pwm_en = 1'b1; tick = 1'b1; counter_en = 1'b1;
            period_reg = W'(vecs[i].period);
            DC_reg     = W'(vecs[i].dc_reg);
            i_DC       = W'(vecs[i].i_dc);
            DC_sel     = vecs[i].dc_sel;
            soft_clear();
            for (int k = 0; k < 2 * vecs[i].period; k++) begin
                check({vecs[i].name, "_cnt"}, counter, k % vecs[i].period);
                check({vecs[i].name, "_pwm_hi"}, pwm,
                      vecs[i].invalid ? 1'b1 : vecs[i].mask[k % vecs[i].period]);
                @(negedge clk); #1;
                check({vecs[i].name, "_pwm_lo"}, pwm,
                      vecs[i].invalid ? 1'b0 : vecs[i].mask[k % vecs[i].period]);
                edge_step();
            end
        end

        // async reset mid-count with pwm high
        mode = 1'b1; DC_sel = 1'b0; period_reg = 16'd6; DC_reg = 16'd6;
        soft_clear();
        repeat (4) edge_step();
        check("midrst_pre_cnt", counter, 4);
        check("midrst_pre_pwm", pwm, 1);
        rst = 1'b1; m_cnt = 0; m_done = 1'b0;
        #1;
        check("midrst_cnt", counter, 0);
        check("midrst_pwm", pwm, 0);
        @(negedge clk);
        rst = 1'b0;

        // one-shot timer: stops at 4, sticky done cleared by async reset
        mode = 1'b0; timer_mode = 1'b0; period_reg = 16'd5;
        soft_clear();
        repeat (8) edge_step();
        check("oneshot_cnt", counter, 4);
        check("oneshot_done", timer_done, 1);
        rst = 1'b1; m_cnt = 0; m_done = 1'b0;
        #1;
        check("oneshot_rst_cnt", counter, 0);
        check("oneshot_rst_done", timer_done, 0);
        @(negedge clk);
        rst = 1'b0;

        // one-shot again: done stays sticky until sw_rst
        repeat (9) edge_step();
        check("oneshot2_cnt", counter, 4);
        check("oneshot2_done", timer_done, 1);
        counter_en = 1'b0;
        repeat (2) edge_step();
        check("oneshot_sticky", timer_done, 1);
        counter_en = 1'b1;
        soft_clear();
        check("oneshot_sw_cnt", counter, 0);
        check("oneshot_sw_done", timer_done, 0);

        // continuous timer: one-cycle done pulse every 5 ticks
        timer_mode = 1'b1;
        soft_clear();
        for (int n = 1; n <= 15; n++) begin
            edge_step();
            check("cont_done", timer_done, (n % 5 == 0) ? 1 : 0);
            check("cont_cnt", counter, n % 5);
        end

        // pwm_en low forces pwm low for valid and invalid duty
        mode = 1'b1; pwm_en = 1'b0; period_reg = 16'd4; DC_reg = 16'd2;
        soft_clear();
        for (int n = 0; n < 4; n++) begin
            check("pwm_en_off", pwm, 0);
            edge_step();
        end
        DC_reg = 16'd9;
        check("pwm_en_off_inval", pwm, 0);
        pwm_en = 1'b1;

        // tick on alternate edges
        period_reg = 16'd8; DC_reg = 16'd4;
        soft_clear();
        for (int n = 1; n <= 8; n++) begin
            tick = n[0];
            edge_step();
            check("tick_alt_cnt", counter, (n + 1) / 2);
        end
        tick = 1'b1;

        // counter_en low freezes the count
        counter_en = 1'b0;
        repeat (3) edge_step();
        check("freeze_cnt", counter, 4);
        counter_en = 1'b1;

        // zero period holds the counter at 0 with no done event
        mode = 1'b0; timer_mode = 1'b1; period_reg = 16'd0;
        repeat (3) edge_step();
        check("period0_cnt", counter, 0);
        check("period0_done", timer_done, 0);

        // randomized run against the reference model
        soft_clear();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 7) == 0) period_reg = W'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 15) == 0) timer_mode = $urandom_range(0, 1) != 0;
            DC_reg     = W'($urandom_range(0, 9));
            i_DC       = W'($urandom_range(0, 9));
            DC_sel     = $urandom_range(0, 1) != 0;
            pwm_en     = $urandom_range(0, 7) != 0;
            tick       = $urandom_range(0, 3) != 0;
            counter_en = $urandom_range(0, 7) != 0;
            sw_rst     = $urandom_range(0, 31) == 0;
            #1;
            check("rnd_pwm_hi", pwm, exp_pwm());
            @(negedge clk); #1;
            check("rnd_pwm_lo", pwm, exp_pwm());
            edge_step();
            check("rnd_cnt", counter, m_cnt);
            check("rnd_done", timer_done, m_done);
        end
        sw_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_timer_core

`default_nettype wire
